operand2_pipe: RTL and testbench
================================

OPERAND2_PIPE -- requirements
Module: operand2_pipe

Interface
REQ-001 Parameter DATA_W, default 32, is the operand width; the legal minimum is 32.
REQ-002 Parameter SHAMT_W, default 5, is the shift-count width; it SHALL equal log2(DATA_W).
REQ-003 Parameter DEPTH, default 2, is the number of output queue entries; it SHALL be a power of 2 and at least 2.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: the reset; it is synchronous and active-low.
REQ-006 Port flush, input, 1 bit: synchronous queue discard.
REQ-007 Port in_valid, input, 1 bit: the instruction and rs2 inputs are valid.
REQ-008 Port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-009 Port in_instr, input, 32 bits: the SPARC instruction word.
REQ-010 Port in_rs2, input, DATA_W bits: the register-file value of rs2.
REQ-011 Port out_valid, output, 1 bit: the queue head is valid.
REQ-012 Port out_ready, input, 1 bit: the consumer takes the queue head.
REQ-013 Port out_n, output, DATA_W bits: the resolved operand2 at the queue head.
REQ-014 Port out_kind, output, 3 bits: the operand class at the queue head.
REQ-015 Port count, output, clog2(DEPTH+1) bits: the number of occupied entries.

Function
REQ-016 Decode SHALL use op=in_instr[31:30], op2=in_instr[24:22], op3=in_instr[24:19] and i=in_instr[13].
REQ-017 When op=00 and op2=100 (SETHI), N SHALL be {imm22,10'b0} zero-extended to DATA_W, with kind 0.
REQ-018 When op=00 and op2 is not 100 (branch), N SHALL be sign-extended disp22 shifted left by 2, with kind 1.
REQ-019 When op=01 (CALL), N SHALL be sign-extended disp30 shifted left by 2, with kind 2.
REQ-020 When op=1x and op3 is in {100101, 100110, 100111} (shift), kind SHALL be 3, and N SHALL be:
- i=1: in_instr[SHAMT_W-1:0] zero-extended;
- i=0: in_rs2[SHAMT_W-1:0] zero-extended.
REQ-021 When op=1x, the instruction is not a shift and i=1, N SHALL be simm13 (in_instr[12:0]) sign-extended to DATA_W, with kind 4.
REQ-022 When op=1x, the instruction is not a shift and i=0, N SHALL be in_rs2, with kind 5.
REQ-023 Kind codes 6 and 7 are reserved and SHALL never be produced.
REQ-024 in_ready SHALL be 1 exactly when rst_n=1 and count<DEPTH, and SHALL not depend on out_ready.
REQ-025 A push SHALL occur when in_valid=1 and in_ready=1; the decoded {N,kind} is written at the tail on that edge.
REQ-026 A pop SHALL occur when out_valid=1 and out_ready=1; the head advances on that edge.
REQ-027 out_valid SHALL be equal to (count!=0), and out_n/out_kind SHALL come directly from the head register.
REQ-028 Latency SHALL be 1 cycle: an entry pushed into an empty queue appears on out_valid/out_n in the next cycle.
REQ-029 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-030 When full, in_ready=0 and the input SHALL be held by the producer; a same-cycle pop does not enable a push.
REQ-031 Pointers SHALL wrap modulo DEPTH with no gap or duplication.
REQ-032 flush=1 SHALL zero count and both pointers at the next edge, have priority over any push or pop that cycle, and leave storage contents don't-care.
REQ-033 in_instr and in_rs2 SHALL be don't-care when in_valid=0, and no state SHALL change from them.

Reset
REQ-034 While rst_n=0 at a rising edge, count, both pointers, and all storage SHALL reset to 0.
REQ-035 After reset, out_valid=0, out_n=0, out_kind=0, and count=0.
REQ-036 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-037 Reset asserted mid-operation SHALL discard all entries; push and pop are ignored in that cycle.

Verification
REQ-038 SETHI: in_instr=0x013FFFFF (DATA_W=32) -> next cycle out_n=0xFFFFFC00, out_kind=0.
REQ-039 Branch and CALL:
- 0x00BFFFFF -> out_n=0xFFFFFFFC, kind 1;
- 0x40000001 -> out_n=0x00000004, kind 2.
REQ-040 Immediate and register forms:
- 0x80003FFF -> out_n=0xFFFFFFFF, kind 4;
- 0x80000002 with in_rs2=0x12345678 -> out_n=0x12345678, kind 5.
REQ-041 Shift forms:
- 0x81283FFF -> out_n=0x0000001F, kind 3;
- 0x81280002 with in_rs2=0xFFFFFFE3 -> out_n=0x00000003.
REQ-042 Fill and drain, DEPTH=2, out_ready=0:
- three back-to-back pushes -> count=2, in_ready=0, third input held;
- then out_ready=1 -> entries drain in order, count decrements, third accepted only after count<2.
REQ-043 Flush, reset and width:
- flush with count=2 plus a simultaneous push -> next cycle count=0, out_valid=0;
- rst_n=0 with count=1 -> count=0, in_ready=0;
- DATA_W=64: 0x80003FFF -> out_n=0xFFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/operand2_pipe.sv
// ============================================================================
// Module      : operand2_pipe
// Description : Decodes the SPARC operand2 value of an instruction and queues
//               {operand, kind} pairs in a small valid/ready FIFO.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module operand2_pipe #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5,
    parameter int DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [DATA_W-1:0]            in_rs2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_n,
    output logic [2:0]                   out_kind,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH+1);

    localparam logic [2:0] C_KIND_SETHI  = 3'd0;
    localparam logic [2:0] C_KIND_BRANCH = 3'd1;
    localparam logic [2:0] C_KIND_CALL   = 3'd2;
    localparam logic [2:0] C_KIND_SHIFT  = 3'd3;
    localparam logic [2:0] C_KIND_SIMM   = 3'd4;
    localparam logic [2:0] C_KIND_REG    = 3'd5;

    logic [DATA_W-1:0]  w_dec_n;
    logic [2:0]         w_dec_kind;
    logic               w_is_shift;
    logic               w_push;
    logic               w_pop;

    logic [C_CNT_W-1:0] count_q,  count_d;
    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  mem_n_q    [DEPTH];
    logic [DATA_W-1:0]  mem_n_d    [DEPTH];
    logic [2:0]         mem_kind_q [DEPTH];
    logic [2:0]         mem_kind_d [DEPTH];

    // Operand2 decode; signed size casts perform the sign extension.
    always_comb begin
        w_dec_n    = '0;
        w_dec_kind = C_KIND_REG;
        w_is_shift = (in_instr[24:19] == 6'b100101) ||
                     (in_instr[24:19] == 6'b100110) ||
                     (in_instr[24:19] == 6'b100111);
        if (in_instr[31:30] == 2'b00) begin
            if (in_instr[24:22] == 3'b100) begin
                w_dec_n    = DATA_W'({in_instr[21:0], 10'b0});
                w_dec_kind = C_KIND_SETHI;
            end else begin
                w_dec_n    = DATA_W'($signed({in_instr[21:0], 2'b00}));
                w_dec_kind = C_KIND_BRANCH;
            end
        end else if (in_instr[31:30] == 2'b01) begin
            w_dec_n    = DATA_W'($signed({in_instr[29:0], 2'b00}));
            w_dec_kind = C_KIND_CALL;
        end else if (w_is_shift) begin
            w_dec_n    = in_instr[13] ? DATA_W'(in_instr[SHAMT_W-1:0])
                                      : DATA_W'(in_rs2[SHAMT_W-1:0]);
            w_dec_kind = C_KIND_SHIFT;
        end else if (in_instr[13]) begin
            w_dec_n    = DATA_W'($signed(in_instr[12:0]));
            w_dec_kind = C_KIND_SIMM;
        end else begin
            w_dec_n    = in_rs2;
            w_dec_kind = C_KIND_REG;
        end
    end

    assign in_ready  = rst_n && (count_q < C_CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_n     = mem_n_q[rd_ptr_q];
    assign out_kind  = mem_kind_q[rd_ptr_q];
    assign count     = count_q;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int e = 0; e < DEPTH; e++) begin
            mem_n_d[e]    = mem_n_q[e];
            mem_kind_d[e] = mem_kind_q[e];
        end
        if (w_push) begin
            mem_n_d[wr_ptr_q]    = w_dec_n;
            mem_kind_d[wr_ptr_q] = w_dec_kind;
        end
        // Flush overrides any push or pop bookkeeping in the same cycle.
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + C_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                count_d = count_q - C_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_n_q[e]    <= '0;
                mem_kind_q[e] <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int e = 0; e < DEPTH; e++) begin
                mem_n_q[e]    <= mem_n_d[e];
                mem_kind_q[e] <= mem_kind_d[e];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_operand2_pipe.sv
// ============================================================================
// Module      : tb_operand2_pipe
// Description : Self-checking bench for operand2_pipe against a queue model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_operand2_pipe;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [63:0] n;
        logic [2:0]  k;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_n;
    logic [2:0]  out_kind;
    logic [1:0]  count;

    logic        in64_valid;
    logic        in64_ready;
    logic [31:0] in64_instr;
    logic [63:0] in64_rs2;
    logic        out64_valid;
    logic [63:0] out64_n;
    logic [2:0]  out64_kind;
    logic [1:0]  count64;

    int checks   = 0;
    int failures = 0;
    bit last_push;
    entry_t q[$];

    always #5 clk = ~clk;

    operand2_pipe #(.DATA_W(32), .SHAMT_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_n(out_n), .out_kind(out_kind), .count(count)
    );

    operand2_pipe #(.DATA_W(64), .SHAMT_W(6), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in64_valid), .in_ready(in64_ready),
        .in_instr(in64_instr), .in_rs2(in64_rs2),
        .out_valid(out64_valid), .out_ready(1'b1),
        .out_n(out64_n), .out_kind(out64_kind), .count(count64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference operand2 value computed with plain integer arithmetic.
    function automatic entry_t ref_decode(input logic [31:0] ins, input logic [63:0] rs2, input int w);
        entry_t r;
        longint d;
        int     op3;
        op3 = int'(ins[24:19]);
        if (ins[31:30] == 2'b00 && ins[24:22] == 3'b100) begin
            r.n = 64'(ins[21:0]) * 64'd1024;
            r.k = 3'd0;
        end else if (ins[31:30] == 2'b00) begin
            d = longint'(ins[21:0]);
            if (d >= 2097152) d -= 4194304;
            r.n = 64'(d * 4);
            r.k = 3'd1;
        end else if (ins[31:30] == 2'b01) begin
            d = longint'(ins[29:0]);
            if (d >= 536870912) d -= 1073741824;
            r.n = 64'(d * 4);
            r.k = 3'd2;
        end else if (op3 == 37 || op3 == 38 || op3 == 39) begin
            r.n = (ins[13] ? 64'(ins) : rs2) % 64'(w);
            r.k = 3'd3;
        end else if (ins[13]) begin
            d = longint'(ins[12:0]);
            if (d >= 4096) d -= 8192;
            r.n = 64'(d);
            r.k = 3'd4;
        end else begin
            r.n = rs2;
            r.k = 3'd5;
        end
        if (w < 64) r.n = r.n & ((64'd1 << w) - 64'd1);
        return r;
    endfunction

    // One clock: predict from current inputs, advance, compare.
    task automatic cycle();
        bit     rdy, push, pop;
        entry_t e;
        rdy  = rst_n && (q.size() < DEPTH);
        push = in_valid && rdy;
        pop  = (q.size() != 0) && out_ready;
        e    = ref_decode(in_instr, 64'(in_rs2), 32);
        @(posedge clk);
        #1;
        if (!rst_n || flush) begin
            q.delete();
            last_push = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            last_push = push;
        end
        chk("count", 64'(count), 64'(q.size()));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(rst_n && (q.size() < DEPTH)));
        if (q.size() != 0) begin
            chk("out_n", 64'(out_n), q[0].n);
            chk("out_kind", 64'(out_kind), 64'(q[0].k));
        end
    endtask

    logic [31:0] vec_instr [6] = '{32'h013FFFFF, 32'h00BFFFFF, 32'h40000001,
                                   32'h80003FFF, 32'h80000002, 32'h81283FFF};
    logic [31:0] vec_rs2   [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'h0};
    logic [31:0] vec_n     [6] = '{32'hFFFFFC00, 32'hFFFFFFFC, 32'h00000004,
                                   32'hFFFFFFFF, 32'h12345678, 32'h0000001F};
    logic [2:0]  vec_k     [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_rs2 = '0;
        in64_valid = 1'b0; in64_instr = '0; in64_rs2 = '0;

        // Reset state
        cycle();
        cycle();
        chk("rst_out_n", 64'(out_n), 64'd0);
        chk("rst_out_kind", 64'(out_kind), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);

        // Decode vectors, back-to-back with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_instr = vec_instr[i];
            in_rs2   = vec_rs2[i];
            cycle();
            chk($sformatf("vec%0d_n", i), 64'(out_n), 64'(vec_n[i]));
            chk($sformatf("vec%0d_kind", i), 64'(out_kind), 64'(vec_k[i]));
        end
        in_instr = 32'h81280002; in_rs2 = 32'hFFFFFFE3;
        cycle();
        chk("shift_rs2_n", 64'(out_n), 64'h3);
        chk("shift_rs2_kind", 64'(out_kind), 64'd3);
        in_valid = 1'b0;
        cycle();

        // Fill and drain
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h40000001; cycle();
        in_instr = 32'h80003FFF; cycle();
        in_instr = 32'h013FFFFF; cycle();
        chk("full_count", 64'(count), 64'd2);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head", 64'(out_n), 64'h4);
        out_ready = 1'b1;
        cycle();
        chk("drain1_count", 64'(count), 64'd1);
        chk("drain1_head", 64'(out_n), 64'hFFFFFFFF);
        cycle();
        chk("drain2_count", 64'(count), 64'd1);
        chk("drain2_head", 64'(out_n), 64'hFFFFFC00);
        in_valid = 1'b0;
        cycle();
        chk("drain3_count", 64'(count), 64'd0);

        // Flush with a simultaneous push
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h80000002; in_rs2 = 32'hA5A5A5A5;
        cycle();
        cycle();
        flush = 1'b1;
        cycle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;

        // Reset mid-operation
        in_valid = 1'b1; cycle();
        in_valid = 1'b0; cycle();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1; in_valid = 1'b0;

        // 64-bit width instance
        in64_valid = 1'b1; in64_instr = 32'h80003FFF;
        cycle();
        chk("w64_n", out64_n, 64'hFFFFFFFFFFFFFFFF);
        chk("w64_n_model", out64_n, ref_decode(32'h80003FFF, 64'd0, 64).n);
        chk("w64_kind", 64'(out64_kind), 64'd4);
        in64_valid = 1'b0;

        // Randomised traffic with flushes and resets
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_push) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_instr = $urandom;
                in_rs2   = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    in_instr[31:30] = {1'b1, 1'($urandom_range(0, 1))};
                    in_instr[24:19] = 6'(37 + $urandom_range(0, 2));
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst_n     = ($urandom_range(0, 63) != 0);
            cycle();
        end
        rst_n = 1'b1; flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
